mem_ctl: RTL and testbench

MEM_CTL -- requirements
Module: mem_ctl

---
 rtl/mem_ctl.sv | 133 +++++++++++++
 tb/tb_mem_ctl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctl.sv
// Single-port word memory behind a request/acknowledge processor interface.
// Each read or write waits a fixed LATENCY cycles before completing.
module mem_ctl #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemWriteReady,
  input  logic        MemReadDone,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWriteData,
  output logic [31:0] memReadData,
  output logic        MemReadReady,
  output logic        MemWriteDone,
  output logic        busy
);

  localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [7:0]  LatCnt = 8'(LATENCY);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRdWait  = 3'd1;
  localparam logic [2:0] StRdReady = 3'd2;
  localparam logic [2:0] StWrWait  = 3'd3;
  localparam logic [2:0] StWrDone  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rready_q, rready_d;
  logic          wdone_q, wdone_d;
  logic          mem_we;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Byte-offset and above-range address bits are deliberately dropped (wrap).
  logic unused_addr;
  assign unused_addr = ^{memAddr[31:AW+2], memAddr[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rready_d = rready_q;
    wdone_d  = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      StIdle: begin
        if (MemWrite && MemWriteReady) begin
          idx_d   = memAddr[AW+1:2];
          wdata_d = memWriteData;
          cnt_d   = LatCnt;
          state_d = StWrWait;
        end else if (MemRead) begin
          idx_d   = memAddr[AW+1:2];
          cnt_d   = LatCnt;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (!MemRead) begin
          cnt_d   = 8'd0;
          state_d = StIdle;
        end else if (cnt_q == 8'd1) begin
          cnt_d    = 8'd0;
          rdata_d  = mem_q[idx_q];
          rready_d = 1'b1;
          state_d  = StRdReady;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StRdReady: begin
        if (MemReadDone) begin
          rready_d = 1'b0;
          state_d  = StIdle;
        end
      end
      StWrWait: begin
        if (cnt_q == 8'd1) begin
          cnt_d   = 8'd0;
          mem_we  = 1'b1;
          wdone_d = 1'b1;
          state_d = StWrDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StWrDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      rready_q <= 1'b0;
      wdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rready_q <= rready_d;
      wdone_q  <= wdone_d;
    end
  end

  // Array is never cleared; reset only suppresses a commit in flight.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign memReadData  = rdata_q;
  assign MemReadReady = rready_q;
  assign MemWriteDone = wdone_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mem_ctl.sv
// Directed and randomized checks of mem_ctl against a word-array reference model.
module tb_mem_ctl;

  localparam int LAT   = 4;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemWriteReady, MemReadDone;
  logic [31:0] memAddr, memWriteData;
  logic [31:0] memReadData;
  logic        MemReadReady, MemWriteDone, busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_vld [DEPTH];
  logic [31:0] wr_addrs [$];

  mem_ctl #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemWriteReady(MemWriteReady),
    .MemReadDone  (MemReadDone),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .memReadData  (memReadData),
    .MemReadReady (MemReadReady),
    .MemWriteDone (MemWriteDone),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(DEPTH));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int k;
    MemWrite = 1'b1; MemWriteReady = 1'b1; memAddr = a; memWriteData = d;
    tick();
    MemWrite = 1'b0; MemWriteReady = 1'b0;
    check("wr_busy", 32'(busy), 32'd1);
    k = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      tick();
      if (MemWriteDone) begin k = i; break; end
    end
    check("wr_latency", 32'(k), 32'(LAT));
    model_mem[widx(a)] = d;
    model_vld[widx(a)] = 1'b1;
    wr_addrs.push_back(a);
    tick();
    check("wr_pulse_end", 32'(MemWriteDone), 32'd0);
    check("wr_idle", 32'(busy), 32'd0);
  endtask

  // Read with a hold of 'hold' cycles in the ready state; optionally push a write meanwhile.
  task automatic do_read(input logic [31:0] a, input int hold, input bit interfere);
    int k;
    logic [31:0] first;
    MemRead = 1'b1; memAddr = a;
    tick();
    check("rd_busy", 32'(busy), 32'd1);
    k = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      tick();
      if (MemReadReady) begin k = i; break; end
    end
    check("rd_latency", 32'(k), 32'(LAT));
    if (model_vld[widx(a)]) check("rd_data", memReadData, model_mem[widx(a)]);
    first = memReadData;
    for (int i = 0; i < hold; i++) begin
      if (interfere) begin
        MemWrite = (i >= 2 && i < 5); MemWriteReady = MemWrite;
        memWriteData = ~first;
      end
      tick();
      check("rd_hold_rdy", 32'(MemReadReady), 32'd1);
      check("rd_hold_data", memReadData, first);
    end
    MemWrite = 1'b0; MemWriteReady = 1'b0;
    MemReadDone = 1'b1; MemRead = 1'b0;
    tick();
    MemReadDone = 1'b0;
    check("rd_done_rdy", 32'(MemReadReady), 32'd0);
    check("rd_done_idle", 32'(busy), 32'd0);
    check("rd_data_keep", memReadData, first);
  endtask

  initial begin
    int k;
    logic [31:0] r, a, d;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemWriteReady = 1'b0;
    MemReadDone = 1'b0; memAddr = 32'd0; memWriteData = 32'd0;
    for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;
    tick(); tick();
    check("rst_rdy", 32'(MemReadReady), 32'd0);
    check("rst_done", 32'(MemWriteDone), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", memReadData, 32'd0);
    reset = 1'b0;
    tick();

    // Write then read
    do_write(32'h10, 32'hDEADBEEF);
    do_read(32'h10, 0, 1'b0);

    // Long hold in ready; a write during the hold must be ignored
    do_read(32'h10, 10, 1'b1);
    do_read(32'h10, 1, 1'b0);

    // Simultaneous read and write: write first, then the still-pending read
    MemRead = 1'b1; MemWrite = 1'b1; MemWriteReady = 1'b1;
    memAddr = 32'h20; memWriteData = 32'h12345678;
    tick();
    MemWrite = 1'b0; MemWriteReady = 1'b0;
    k = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      tick();
      check("sim_no_rdy", 32'(MemReadReady), 32'd0);
      if (MemWriteDone) begin k = i; break; end
    end
    check("sim_wr_latency", 32'(k), 32'(LAT));
    model_mem[widx(32'h20)] = 32'h12345678;
    model_vld[widx(32'h20)] = 1'b1;
    tick();
    check("sim_idle_gap", 32'(busy), 32'd0);
    tick();
    check("sim_rd_accept", 32'(busy), 32'd1);
    k = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      tick();
      if (MemReadReady) begin k = i; break; end
    end
    check("sim_rd_latency", 32'(k), 32'(LAT));
    check("sim_rd_data", memReadData, 32'h12345678);
    MemReadDone = 1'b1; MemRead = 1'b0;
    tick();
    MemReadDone = 1'b0;

    // Address wrap modulo the array depth
    do_write(32'h1004, 32'hA5A5A5A5);
    do_read(32'h0004, 0, 1'b0);
    do_read(32'h0007, 0, 1'b0);
    check("wrap_data", memReadData, 32'hA5A5A5A5);

    // Reset two cycles into the write wait aborts the write
    do_write(32'h0, 32'h11111111);
    MemWrite = 1'b1; MemWriteReady = 1'b1; memAddr = 32'h0; memWriteData = 32'h55555555;
    tick();
    MemWrite = 1'b0; MemWriteReady = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rstw_rdy", 32'(MemReadReady), 32'd0);
    check("rstw_done", 32'(MemWriteDone), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_data", memReadData, 32'd0);
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      if (MemWriteDone) k++;
    end
    check("rstw_no_pulse", 32'(k), 32'd0);
    do_read(32'h0, 0, 1'b0);
    check("rstw_kept", memReadData, 32'h11111111);

    // Read abort when MemRead drops mid-wait
    MemRead = 1'b1; memAddr = 32'h10;
    tick();
    tick();
    MemRead = 1'b0;
    tick();
    check("abort_idle", 32'(busy), 32'd0);
    k = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      if (MemReadReady) k++;
      tick();
    end
    check("abort_no_rdy", 32'(k), 32'd0);

    // Reset while read data is presented drops it
    MemRead = 1'b1; memAddr = 32'h10;
    for (int i = 0; i <= LAT; i++) tick();
    check("rstr_rdy_pre", 32'(MemReadReady), 32'd1);
    reset = 1'b1; MemRead = 1'b0;
    tick();
    reset = 1'b0;
    check("rstr_rdy", 32'(MemReadReady), 32'd0);
    check("rstr_busy", 32'(busy), 32'd0);
    tick();

    // Randomized mix of writes and reads of written words with aliased addresses
    for (int n = 0; n < 40; n++) begin
      r = $urandom();
      if (wr_addrs.size() == 0 || r[0]) begin
        a = $urandom();
        d = $urandom();
        do_write(a, d);
      end else begin
        a = wr_addrs[$urandom_range(wr_addrs.size() - 1)];
        a = (r & 32'hFFFF_F003) | (a & 32'h0000_0FFC);
        do_read(a, int'($urandom_range(3)), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
